// File: rtl/spi_master_pkg.sv
// Shared definitions for the FIFO-buffered SPI master: register map,
// STATUS/CONTROL bit positions, shift-engine state encoding and word-length helper.
package spi_master_pkg;

  localparam logic [2:0] ADDR_RXDATA   = 3'd0;
  localparam logic [2:0] ADDR_TXDATA   = 3'd1;
  localparam logic [2:0] ADDR_STATUS   = 3'd2;
  localparam logic [2:0] ADDR_CONTROL  = 3'd3;
  localparam logic [2:0] ADDR_CLKDIV   = 3'd4;
  localparam logic [2:0] ADDR_SLAVESEL = 3'd5;
  localparam logic [2:0] ADDR_NBITS    = 3'd6;

  localparam int ST_ROE  = 0;
  localparam int ST_TOE  = 1;
  localparam int ST_TMT  = 2;
  localparam int ST_TRDY = 3;
  localparam int ST_RRDY = 4;
  localparam int ST_BUSY = 5;

  localparam int CT_CPOL  = 0;
  localparam int CT_CPHA  = 1;
  localparam int CT_LSB   = 2;
  localparam int CT_SSO   = 3;
  localparam int CT_IROE  = 4;
  localparam int CT_ITOE  = 5;
  localparam int CT_ITRDY = 6;
  localparam int CT_IRRDY = 7;
  localparam int CT_ITMT  = 8;
  localparam int CTRL_W   = 9;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LEAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_TRAIL = 2'd3
  } spi_state_e;

  // A programmed length of 0 or one longer than the shifter means "full width".
  function automatic logic [5:0] sat_nbits(input logic [5:0] raw, input int unsigned dw);
    if (raw == 6'd0 || 32'(raw) > dw) return 6'(dw);
    return raw;
  endfunction

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO with show-ahead read data. Pointers carry one extra
// wrap bit so full and empty are distinguishable; push when full and pop
// when empty are ignored, so callers may request either unconditionally.
module spi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign level_o = wr_q - rd_q;
  assign dout_o  = mem_q[rd_q[AW-1:0]];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Storage and pointer update; simultaneous push and pop leave the level unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q[AW-1:0]] <= din_i;
        wr_q                <= wr_q + PTR_ONE;
      end
      if (do_pop) rd_q <= rd_q + PTR_ONE;
    end
  end

endmodule

// File: rtl/spi_master_fifo.sv
// Memory-mapped SPI master with TX/RX FIFOs. The bus side owns the
// programming registers and sticky error flags; the shift engine latches
// mode, order, divider, length and select mask at the start of every word
// so register writes during a transfer only affect the following word.
module spi_master_fifo
  import spi_master_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SLAVES = 1,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_RESET  = 406
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_select,
  input  logic [2:0]            mem_addr,
  input  logic                  read_n,
  input  logic                  write_n,
  input  logic [31:0]           data_from_cpu,
  output logic [31:0]           data_to_cpu,
  output logic                  irq,
  input  logic                  MISO,
  output logic                  MOSI,
  output logic                  SCLK,
  output logic [NUM_SLAVES-1:0] SS_n
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DATA_WIDTH-1:0] ONE     = 1;
  localparam logic [NUM_SLAVES-1:0] SEL_RST = 1;

  // Bus-side registers
  logic [CTRL_W-1:0]     ctrl_q;
  logic [15:0]           div_q;
  logic [5:0]            nbits_q;
  logic [NUM_SLAVES-1:0] sel_q;
  logic                  roe_q, toe_q;
  logic [31:0]           data_q;
  logic                  irq_q;

  // Shift engine state
  spi_state_e            state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [6:0]            edge_q, edge_d;
  logic [DATA_WIDTH-1:0] txsh_q, txsh_d;
  logic [DATA_WIDTH-1:0] rxsh_q, rxsh_d;
  logic                  sclk_q, sclk_d;
  logic [NUM_SLAVES-1:0] ssn_q, ssn_d;
  logic                  cpol_q, cpol_d;
  logic                  cpha_q, cpha_d;
  logic                  lsb_q, lsb_d;
  logic [15:0]           wdiv_q, wdiv_d;
  logic [5:0]            wnb_q, wnb_d;

  logic                  load, edge_odd, do_sample, do_shift;
  logic [DATA_WIDTH-1:0] nb_top;

  // Bus decode and FIFO handshakes
  logic                  rd_en, wr_en, status_wr;
  logic                  tx_push, tx_pop, tx_full, tx_empty;
  logic                  rx_push, rx_push_req, rx_pop, rx_full, rx_empty;
  logic                  toe_set, roe_set;
  logic [DATA_WIDTH-1:0] tx_dout, rx_dout;
  logic [LW-1:0]         tx_level, rx_level;
  logic [31:0]           status_w, rd_data;
  logic                  busy, tmt, irq_d;
  logic                  bus_unused;

  assign rd_en     = spi_select & ~read_n;
  assign wr_en     = spi_select & ~write_n;
  assign status_wr = wr_en && (mem_addr == ADDR_STATUS);
  assign tx_push   = wr_en && (mem_addr == ADDR_TXDATA) && !tx_full;
  assign toe_set   = wr_en && (mem_addr == ADDR_TXDATA) && tx_full;
  assign rx_pop    = rd_en && (mem_addr == ADDR_RXDATA) && !rx_empty;
  assign rx_push   = rx_push_req & ~rx_full;
  assign roe_set   = rx_push_req & rx_full;
  assign bus_unused = ^data_from_cpu;

  spi_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (tx_push),
    .din_i   (data_from_cpu[DATA_WIDTH-1:0]),
    .pop_i   (tx_pop),
    .dout_o  (tx_dout),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .level_o (tx_level)
  );

  spi_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (rx_push),
    .din_i   (rxsh_q),
    .pop_i   (rx_pop),
    .dout_o  (rx_dout),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .level_o (rx_level)
  );

  assign busy   = (state_q != S_IDLE);
  assign tmt    = (state_q == S_IDLE) && tx_empty;
  // Bit position of the first-transmitted MSB within the active word length.
  assign nb_top = ONE << (wnb_q - 6'd1);
  assign MOSI   = lsb_q ? txsh_q[0] : |(txsh_q & nb_top);
  assign SCLK   = sclk_q;
  assign SS_n   = ssn_q;
  assign data_to_cpu = data_q;
  assign irq    = irq_q;

  // STATUS image and interrupt request from flags gated by their enables.
  always_comb begin
    status_w            = '0;
    status_w[ST_ROE]    = roe_q;
    status_w[ST_TOE]    = toe_q;
    status_w[ST_TMT]    = tmt;
    status_w[ST_TRDY]   = ~tx_full;
    status_w[ST_RRDY]   = ~rx_empty;
    status_w[ST_BUSY]   = busy;
    status_w[8 +: LW]   = tx_level;
    status_w[16 +: LW]  = rx_level;
    irq_d = (roe_q     & ctrl_q[CT_IROE])  |
            (toe_q     & ctrl_q[CT_ITOE])  |
            (~tx_full  & ctrl_q[CT_ITRDY]) |
            (~rx_empty & ctrl_q[CT_IRRDY]) |
            (tmt       & ctrl_q[CT_ITMT]);
  end

  // Read mux; RXDATA of an empty FIFO and the reserved slot read as zero.
  always_comb begin
    rd_data = '0;
    case (mem_addr)
      ADDR_RXDATA:   if (!rx_empty) rd_data[DATA_WIDTH-1:0] = rx_dout;
      ADDR_STATUS:   rd_data = status_w;
      ADDR_CONTROL:  rd_data[CTRL_W-1:0] = ctrl_q;
      ADDR_CLKDIV:   rd_data[15:0] = div_q;
      ADDR_SLAVESEL: rd_data[NUM_SLAVES-1:0] = sel_q;
      ADDR_NBITS:    rd_data[5:0] = nbits_q;
      default:       rd_data = '0;
    endcase
  end

  // Programming registers, sticky error flags (set beats clear), read data and irq.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q  <= '0;
      div_q   <= 16'(DIV_RESET);
      nbits_q <= 6'(DATA_WIDTH);
      sel_q   <= SEL_RST;
      roe_q   <= 1'b0;
      toe_q   <= 1'b0;
      data_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      if (wr_en) begin
        case (mem_addr)
          ADDR_CONTROL:  ctrl_q  <= data_from_cpu[CTRL_W-1:0];
          ADDR_CLKDIV:   div_q   <= data_from_cpu[15:0];
          ADDR_SLAVESEL: sel_q   <= data_from_cpu[NUM_SLAVES-1:0];
          ADDR_NBITS:    nbits_q <= data_from_cpu[5:0];
          default: ;
        endcase
      end
      if (roe_set)        roe_q <= 1'b1;
      else if (status_wr) roe_q <= 1'b0;
      if (toe_set)        toe_q <= 1'b1;
      else if (status_wr) toe_q <= 1'b0;
      if (rd_en) data_q <= rd_data;
      irq_q <= irq_d;
    end
  end

  // Shift engine next state: half-period timing, edge actions, word load/retire.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    edge_d      = edge_q;
    txsh_d      = txsh_q;
    rxsh_d      = rxsh_q;
    sclk_d      = sclk_q;
    ssn_d       = ssn_q;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    lsb_d       = lsb_q;
    wdiv_d      = wdiv_q;
    wnb_d       = wnb_q;
    load        = 1'b0;
    tx_pop      = 1'b0;
    rx_push_req = 1'b0;
    edge_odd    = ~edge_q[0];
    do_sample   = 1'b0;
    do_shift    = 1'b0;

    case (state_q)
      S_IDLE: begin
        sclk_d = ctrl_q[CT_CPOL];
        ssn_d  = ctrl_q[CT_SSO] ? ~sel_q : '1;
        if (!tx_empty) load = 1'b1;
      end
      S_LEAD: begin
        if (cnt_q == wdiv_q) begin
          cnt_d   = '0;
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_SHIFT: begin
        if (cnt_q == wdiv_q) begin
          cnt_d  = '0;
          edge_d = edge_q + 7'd1;
          sclk_d = ~sclk_q;
          // CPHA=1 presents the first bit from load, so its first leading edge has nothing to shift.
          if (cpha_q) begin
            do_sample = ~edge_odd;
            do_shift  = edge_odd && (edge_q != 7'd0);
          end else begin
            do_sample = edge_odd;
            do_shift  = ~edge_odd;
          end
          if (do_sample) begin
            if (lsb_q) rxsh_d = (rxsh_q >> 1) | (MISO ? nb_top : '0);
            else       rxsh_d = {rxsh_q[DATA_WIDTH-2:0], MISO};
          end
          if (do_shift) txsh_d = lsb_q ? (txsh_q >> 1) : (txsh_q << 1);
          if (edge_d == {wnb_q, 1'b0}) state_d = S_TRAIL;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_TRAIL: begin
        if (cnt_q == wdiv_q) begin
          cnt_d       = '0;
          rx_push_req = 1'b1;
          if (!tx_empty) begin
            load = 1'b1;
          end else begin
            state_d = S_IDLE;
            if (!ctrl_q[CT_SSO]) ssn_d = '1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      tx_pop  = 1'b1;
      txsh_d  = tx_dout;
      rxsh_d  = '0;
      cpol_d  = ctrl_q[CT_CPOL];
      cpha_d  = ctrl_q[CT_CPHA];
      lsb_d   = ctrl_q[CT_LSB];
      wdiv_d  = div_q;
      wnb_d   = sat_nbits(nbits_q, DATA_WIDTH);
      ssn_d   = ~sel_q;
      sclk_d  = ctrl_q[CT_CPOL];
      cnt_d   = '0;
      edge_d  = '0;
      state_d = S_LEAD;
    end
  end

  // Shift engine registers; reset aborts any word in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      edge_q  <= '0;
      txsh_q  <= '0;
      rxsh_q  <= '0;
      sclk_q  <= 1'b0;
      ssn_q   <= '1;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
      wdiv_q  <= '0;
      wnb_q   <= 6'(DATA_WIDTH);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
      txsh_q  <= txsh_d;
      rxsh_q  <= rxsh_d;
      sclk_q  <= sclk_d;
      ssn_q   <= ssn_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      lsb_q   <= lsb_d;
      wdiv_q  <= wdiv_d;
      wnb_q   <= wnb_d;
    end
  end

endmodule

// File: tb/tb_spi_master_fifo.sv
// Directed bench for spi_master_fifo: MOSI looped back to MISO, register
// accesses through bus tasks, SCLK/SS_n activity tallied by edge monitors.
module tb_spi_master_fifo;

  localparam logic [2:0] A_RX = 3'd0, A_TX = 3'd1, A_ST = 3'd2, A_CT = 3'd3;
  localparam logic [2:0] A_DIV = 3'd4, A_SEL = 3'd5, A_NB = 3'd6, A_RSV = 3'd7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        spi_select = 1'b0;
  logic [2:0]  mem_addr = 3'd0;
  logic        read_n = 1'b1;
  logic        write_n = 1'b1;
  logic [31:0] data_from_cpu = 32'd0;
  logic [31:0] data_to_cpu;
  logic        irq;
  logic        MISO;
  logic        MOSI;
  logic        SCLK;
  logic [1:0]  SS_n;

  int n_checks = 0;
  int n_fail   = 0;

  int  rise_cnt = 0;
  int  fall_cnt = 0;
  int  ss_rise  = 0;
  int  bad_sclk = 0;
  time t_rise = 0;
  time t_rise_prev = 0;
  logic [7:0] cap = 8'd0;

  assign MISO = MOSI;

  spi_master_fifo #(
    .DATA_WIDTH(16),
    .NUM_SLAVES(2),
    .FIFO_DEPTH(4),
    .DIV_RESET (406)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .spi_select    (spi_select),
    .mem_addr      (mem_addr),
    .read_n        (read_n),
    .write_n       (write_n),
    .data_from_cpu (data_from_cpu),
    .data_to_cpu   (data_to_cpu),
    .irq           (irq),
    .MISO          (MISO),
    .MOSI          (MOSI),
    .SCLK          (SCLK),
    .SS_n          (SS_n)
  );

  always #5 clk = ~clk;

  always @(posedge SCLK) begin
    rise_cnt++;
    t_rise_prev = t_rise;
    t_rise = $time;
    cap = {MOSI, cap[7:1]};
    if (SS_n[0]) bad_sclk++;
  end
  always @(negedge SCLK) fall_cnt++;
  always @(posedge SS_n[0]) ss_rise++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    spi_select = 1'b1; write_n = 1'b0; mem_addr = a; data_from_cpu = d;
    @(negedge clk);
    spi_select = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    spi_select = 1'b1; read_n = 1'b0; mem_addr = a;
    @(negedge clk);
    spi_select = 1'b0; read_n = 1'b1;
    d = data_to_cpu;
  endtask

  task automatic wait_tmt(input string tag, input int max_polls);
    logic [31:0] s;
    logic        done;
    done = 1'b0;
    for (int i = 0; i < max_polls && !done; i++) begin
      bus_read(A_ST, s);
      if (s[2]) done = 1'b1;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    int rb, fb, sb, bb, eb;
    logic hit;

    // Reset state and register defaults
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_dout", data_to_cpu, 32'd0);
    chk("rst_irq",  32'(irq),  32'd0);
    chk("rst_mosi", 32'(MOSI), 32'd0);
    chk("rst_sclk", 32'(SCLK), 32'd0);
    chk("rst_ssn",  32'(SS_n), 32'd3);
    bus_read(A_DIV, d); chk("rst_div", d, 32'd406);
    bus_read(A_NB, d);  chk("rst_nbits", d, 32'd16);
    bus_read(A_CT, d);  chk("rst_ctrl", d, 32'd0);
    bus_read(A_SEL, d); chk("rst_sel", d, 32'd1);
    bus_read(A_ST, d);  chk("rst_status", d, 32'h0000_000C);
    bus_read(A_RSV, d); chk("rsv_read", d, 32'd0);

    // Mode 0, 8-bit word 0xA5, 4-cycle SCLK period
    bus_write(A_DIV, 32'd1);
    bus_write(A_NB, 32'd8);
    rb = rise_cnt; fb = fall_cnt; bb = bad_sclk;
    bus_write(A_TX, 32'h0000_00A5);
    repeat (3) @(negedge clk);
    chk("m0_ss_active", 32'(SS_n), 32'd2);
    wait_tmt("m0", 200);
    chk("m0_rises", 32'(rise_cnt - rb), 32'd8);
    chk("m0_falls", 32'(fall_cnt - fb), 32'd8);
    chk("m0_period", 32'(t_rise - t_rise_prev), 32'd40);
    chk("m0_ss_outside", 32'(bad_sclk - bb), 32'd0);
    chk("m0_ss_idle", 32'(SS_n), 32'd3);
    chk("m0_sclk_idle", 32'(SCLK), 32'd0);
    bus_read(A_RX, d); chk("m0_rx", d, 32'h0000_00A5);
    bus_read(A_RX, d); chk("m0_rx_empty", d, 32'd0);

    // Mode 3, LSB first, word 0x01
    bus_write(A_CT, 32'h0000_0007);
    repeat (2) @(negedge clk);
    chk("m3_sclk_idle_hi", 32'(SCLK), 32'd1);
    rb = rise_cnt; fb = fall_cnt;
    bus_write(A_TX, 32'h0000_0001);
    @(negedge clk);
    chk("m3_first_bit", 32'(MOSI), 32'd1);
    wait_tmt("m3", 200);
    chk("m3_rises", 32'(rise_cnt - rb), 32'd8);
    chk("m3_falls", 32'(fall_cnt - fb), 32'd8);
    chk("m3_rise_capture", 32'(cap), 32'h0000_0001);
    chk("m3_sclk_end_hi", 32'(SCLK), 32'd1);
    bus_read(A_RX, d); chk("m3_rx", d, 32'h0000_0001);
    bus_write(A_CT, 32'd0);
    repeat (2) @(negedge clk);

    // Four-word burst with SS_n held low throughout
    rb = rise_cnt; sb = ss_rise;
    bus_write(A_TX, 32'h11);
    bus_write(A_TX, 32'h22);
    bus_write(A_TX, 32'h33);
    bus_write(A_TX, 32'h44);
    chk("burst_irq_off", 32'(irq), 32'd0);
    wait_tmt("burst", 400);
    chk("burst_rises", 32'(rise_cnt - rb), 32'd32);
    chk("burst_ss_deassert_once", 32'(ss_rise - sb), 32'd1);
    bus_read(A_RX, d); chk("burst_rx0", d, 32'h11);
    bus_read(A_RX, d); chk("burst_rx1", d, 32'h22);
    bus_read(A_RX, d); chk("burst_rx2", d, 32'h33);
    bus_read(A_RX, d); chk("burst_rx3", d, 32'h44);
    bus_read(A_ST, d); chk("burst_status", d, 32'h0000_000C);
    bus_write(A_CT, 32'h0000_0100);
    @(negedge clk);
    chk("itmt_irq", 32'(irq), 32'd1);
    bus_write(A_CT, 32'd0);
    @(negedge clk);
    chk("itmt_irq_off", 32'(irq), 32'd0);

    // TX overflow while the shifter is busy, then RX overflow
    bus_write(A_DIV, 32'd20);
    bus_write(A_TX, 32'h01);
    bus_write(A_TX, 32'h02);
    bus_write(A_TX, 32'h03);
    bus_write(A_TX, 32'h04);
    bus_write(A_TX, 32'h05);
    bus_write(A_TX, 32'h06);
    bus_read(A_ST, d); chk("toe_status", d, 32'h0000_0422);
    wait_tmt("ovf", 3000);
    bus_read(A_ST, d); chk("roe_status", d, 32'h0004_001F);
    bus_write(A_ST, 32'd0);
    bus_read(A_ST, d); chk("err_cleared", d, 32'h0004_001C);
    bus_read(A_RX, d); chk("ovf_rx0", d, 32'h01);
    bus_read(A_RX, d); chk("ovf_rx1", d, 32'h02);
    bus_read(A_RX, d); chk("ovf_rx2", d, 32'h03);
    bus_read(A_RX, d); chk("ovf_rx3", d, 32'h04);

    // 12-bit word, then NBITS=0 saturating to the full 16 bits
    bus_write(A_DIV, 32'd1);
    bus_write(A_NB, 32'd12);
    rb = rise_cnt;
    bus_write(A_TX, 32'h0000_0ABC);
    wait_tmt("nb12", 200);
    chk("nb12_rises", 32'(rise_cnt - rb), 32'd12);
    bus_read(A_RX, d); chk("nb12_rx", d, 32'h0000_0ABC);
    bus_write(A_NB, 32'd0);
    rb = rise_cnt;
    bus_write(A_TX, 32'h0000_BEEF);
    wait_tmt("nb0", 200);
    chk("nb0_rises", 32'(rise_cnt - rb), 32'd16);
    bus_read(A_RX, d); chk("nb0_rx", d, 32'h0000_BEEF);

    // Reset at the fifth SCLK edge of a word
    eb = rise_cnt + fall_cnt;
    bus_write(A_TX, 32'h3C);
    bus_write(A_TX, 32'h5A);
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if ((rise_cnt + fall_cnt - eb) >= 5) hit = 1'b1;
    end
    chk("abort_edge5", 32'(rise_cnt + fall_cnt - eb), 32'd5);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_ssn", 32'(SS_n), 32'd3);
    chk("abort_sclk", 32'(SCLK), 32'd0);
    chk("abort_mosi", 32'(MOSI), 32'd0);
    reset = 1'b0;
    bus_read(A_ST, d); chk("abort_status", d, 32'h0000_000C);
    bus_read(A_RX, d); chk("abort_rx_empty", d, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
